// File: rtl/blob_bbox_tracker.sv
// Per-frame bounding box, pixel count and EMA-smoothed centre of a masked blob.
// The box area is the depth cue for the downstream hand/head tracker.
module blob_bbox_tracker #(
  parameter int MIN_PIXELS   = 64,
  parameter int SMOOTH_SHIFT = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  input  logic        tabulate_in,
  output logic [10:0] x_min_out,
  output logic [10:0] x_max_out,
  output logic [9:0]  y_min_out,
  output logic [9:0]  y_max_out,
  output logic [19:0] count_out,
  output logic [10:0] x_center_out,
  output logic [9:0]  y_center_out,
  output logic        detected_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {S_ACCUM, S_CENTER, S_FILTER, S_REPORT} state_t;

  localparam logic [19:0] MINP = 20'(MIN_PIXELS);

  state_t r_state, w_next;

  logic [10:0] r_xmin, r_xmax, r_s_xmin, r_s_xmax, r_raw_x, r_sm_x;
  logic [9:0]  r_ymin, r_ymax, r_s_ymin, r_s_ymax, r_raw_y, r_sm_y;
  logic [19:0] r_cnt, r_s_cnt, w_cnt_inc;
  logic        r_primed;

  logic        w_tab, w_det;
  logic [11:0] w_sum_x;
  logic [10:0] w_sum_y;
  logic signed [12:0] w_dx, w_dy, w_nx, w_ny;
  logic [10:0] w_fx;
  logic [9:0]  w_fy;

  assign w_tab     = tabulate_in && (r_state == S_ACCUM);
  assign w_cnt_inc = (r_cnt == 20'hFFFFF) ? r_cnt : r_cnt + 20'd1;
  assign w_sum_x   = {1'b0, r_s_xmin} + {1'b0, r_s_xmax};
  assign w_sum_y   = {1'b0, r_s_ymin} + {1'b0, r_s_ymax};
  assign w_det     = (r_s_cnt >= MINP);
  assign valid_out = (r_state == S_REPORT);

  // Signed 13-bit step toward the raw centre, arithmetic shift rounds toward -inf.
  assign w_dx = $signed({2'b00, r_raw_x}) - $signed({2'b00, r_sm_x});
  assign w_dy = $signed({3'b000, r_raw_y}) - $signed({3'b000, r_sm_y});
  assign w_nx = $signed({2'b00, r_sm_x}) + (w_dx >>> SMOOTH_SHIFT);
  assign w_ny = $signed({3'b000, r_sm_y}) + (w_dy >>> SMOOTH_SHIFT);

  always_comb begin
    w_fx = w_nx[10:0];
    if (w_nx < 0)                  w_fx = 11'd0;
    else if (w_nx > 13'sd2047)     w_fx = 11'd2047;
    w_fy = w_ny[9:0];
    if (w_ny < 0)                  w_fy = 10'd0;
    else if (w_ny > 13'sd1023)     w_fy = 10'd1023;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ACCUM:  if (tabulate_in) w_next = S_CENTER;
      S_CENTER: w_next = S_FILTER;
      S_FILTER: w_next = S_REPORT;
      default:  w_next = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_ACCUM;
    else        r_state <= w_next;
  end

  // Accumulators run in every state so the pixel stream is never dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_xmin <= 11'd2047; r_xmax <= 11'd0;
      r_ymin <= 10'd1023; r_ymax <= 10'd0;
      r_cnt  <= 20'd0;
      r_s_xmin <= 11'd0; r_s_xmax <= 11'd0;
      r_s_ymin <= 10'd0; r_s_ymax <= 10'd0;
      r_s_cnt  <= 20'd0;
    end else if (w_tab) begin
      r_s_xmin <= r_xmin; r_s_xmax <= r_xmax;
      r_s_ymin <= r_ymin; r_s_ymax <= r_ymax;
      r_s_cnt  <= r_cnt;
      if (valid_in) begin
        r_xmin <= x_in; r_xmax <= x_in;
        r_ymin <= y_in; r_ymax <= y_in;
        r_cnt  <= 20'd1;
      end else begin
        r_xmin <= 11'd2047; r_xmax <= 11'd0;
        r_ymin <= 10'd1023; r_ymax <= 10'd0;
        r_cnt  <= 20'd0;
      end
    end else if (valid_in) begin
      if (x_in < r_xmin) r_xmin <= x_in;
      if (x_in > r_xmax) r_xmax <= x_in;
      if (y_in < r_ymin) r_ymin <= y_in;
      if (y_in > r_ymax) r_ymax <= y_in;
      r_cnt <= w_cnt_inc;
    end
  end

  // FILTER registers the outputs so they are stable for the whole REPORT cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_raw_x <= 11'd0; r_raw_y <= 10'd0;
      r_sm_x  <= 11'd0; r_sm_y  <= 10'd0;
      r_primed <= 1'b0;
      x_min_out <= 11'd0; x_max_out <= 11'd0;
      y_min_out <= 10'd0; y_max_out <= 10'd0;
      count_out <= 20'd0;
      x_center_out <= 11'd0; y_center_out <= 10'd0;
      detected_out <= 1'b0;
    end else begin
      if (r_state == S_CENTER) begin
        r_raw_x <= w_sum_x[11:1];
        r_raw_y <= w_sum_y[10:1];
      end
      if (r_state == S_FILTER) begin
        count_out    <= r_s_cnt;
        detected_out <= w_det;
        if (w_det) begin
          x_min_out <= r_s_xmin; x_max_out <= r_s_xmax;
          y_min_out <= r_s_ymin; y_max_out <= r_s_ymax;
          r_primed  <= 1'b1;
          if (r_primed) begin
            r_sm_x <= w_fx; r_sm_y <= w_fy;
            x_center_out <= w_fx; y_center_out <= w_fy;
          end else begin
            r_sm_x <= r_raw_x; r_sm_y <= r_raw_y;
            x_center_out <= r_raw_x; y_center_out <= r_raw_y;
          end
        end else begin
          r_primed <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/blob_bbox_tracker.md
Name: blob_bbox_tracker

Overview:
- Downstream of the threshold stage, in parallel with center_of_mass; consumes per-pixel mask bit plus pipelined hcount/vcount.
- Accumulates bounding box and pixel count of masked pixels over one frame.
- At frame boundary reports box, raw box centre, exponentially smoothed centre and a detected flag; box area is the depth cue for the hand/head tracking stage.

Parameters:
- MIN_PIXELS, 64: minimum masked-pixel count per frame for detected_out=1.
- SMOOTH_SHIFT, 2: EMA weight; smoothed += (raw - smoothed) >>> SMOOTH_SHIFT. Legal range 0..4; 0 means no smoothing.

Ports:
- clk_in  input  1  system clock (65 MHz video clock). Single clock domain.
- rst_in  input  1  reset; synchronous, active-high.
- x_in  input  11  pixel column, pipelined to match valid_in.
- y_in  input  10  pixel row, pipelined to match valid_in.
- valid_in  input  1  mask bit: pixel belongs to blob.
- tabulate_in  input  1  one-cycle frame-boundary strobe (hcount==0 && vcount==0).
- x_min_out  output  11  left edge of last reported box.
- x_max_out  output  11  right edge.
- y_min_out  output  10  top edge.
- y_max_out  output  10  bottom edge.
- count_out  output  20  masked-pixel count of last frame.
- x_center_out  output  11  smoothed box centre x.
- y_center_out  output  10  smoothed box centre y.
- detected_out  output  1  last frame count >= MIN_PIXELS.
- valid_out  output  1  one-cycle pulse; all outputs updated and stable.

Behaviour:
- Reset: all outputs 0. State ACCUM. Accumulators at their empty values: xmin=2047, xmax=0, ymin=1023, ymax=0, count=0. Smoothed-centre "primed" flag cleared.
- ACCUM, valid_in=1, tabulate_in=0:
  - xmin=min(xmin,x_in); xmax=max(xmax,x_in); same for y.
  - count+1, saturating at 2^20-1.
- ACCUM, tabulate_in=1:
  - Snapshot accumulators into report registers.
  - Reload accumulators. If valid_in is also 1 that cycle, the pixel is the first member of the new frame (min=max=coordinate, count=1); otherwise reload to empty values.
  - Go to CENTER.
- CENTER (1 cycle): raw_x=(xmin+xmax)>>1 and raw_y likewise, computed at 12/11-bit width with no overflow. Go to FILTER.
- FILTER (1 cycle):
  - If snapshot count >= MIN_PIXELS:
    - If primed=0: smoothed=raw, and set primed.
    - Else: smoothed = smoothed + ((raw - smoothed) >>> SMOOTH_SHIFT), using signed 13-bit difference with arithmetic shift; result clamped to 0..2047 (x) and 0..1023 (y).
    - Set detected_next=1.
  - Else: detected_next=0; clear primed; smoothed held.
  - Go to REPORT.
- REPORT (1 cycle):
  - Drive valid_out=1.
  - Load outputs from snapshot, smoothed centre and detected_next. If not detected, box outputs hold their previous values; count_out still updates.
  - Go to ACCUM.
- Latency: valid_out asserts exactly 3 cycles after the tabulate_in cycle. Outputs hold until the next REPORT.
- Accumulation continues in CENTER/FILTER/REPORT; the pixel stream is never stalled or dropped.
- tabulate_in while not in ACCUM is ignored entirely: no snapshot, no accumulator clear.
- Empty frame (count=0): detected_out=0, count_out=0, valid_out still pulses.
- rst_in mid-report: abort immediately to the reset state; no valid_out pulse.
- Coordinates are unsigned. Width rules: x 11 bits, y 10 bits, count 20 bits.

Test Plan:
- Masked pixels at (100,50),(300,50),(100,200),(300,200) (count forced >= MIN_PIXELS by 60 more interior pixels), then tabulate -> valid_out 3 cycles later; box 100/300/50/200; count_out=64; centre (200,125) (first detection, unfiltered); detected_out=1.
- Second frame box x 200..400, y 125..225 (centre 300,175), SMOOTH_SHIFT=2 -> x_center_out=225, y_center_out=137.
- Frame with 10 masked pixels -> detected_out=0, count_out=10, box outputs unchanged, valid_out pulses; following good frame loads centre unfiltered.
- valid_in=1 at (5,7) on the tabulate cycle -> that pixel excluded from the report; next frame report has x_min=5, y_min=7 and counts it.
- Second tabulate 1 cycle after the first -> ignored; exactly one valid_out pulse; accumulation unaffected.
- rst_in asserted in FILTER -> no valid_out; all outputs 0 next cycle; next frame reports normally.
